// File: rtl/pseudo_spi_rd_intf.sv
// pseudo_spi_rd_intf: read-direction pseudo-SPI master for the analog chain.
// Loads the chain, shifts it in MSB-first, writes bytes to SRAM downward.
module pseudo_spi_rd_intf #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  BGN,
  input  logic [ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [LEN_WIDTH-1:0]  DATA_LEN,
  input  logic                  SPI_SI,
  output logic                  SCLK1,
  output logic                  SCLK2,
  output logic                  SEL,
  output logic                  CEN,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  D_WE,
  output logic                  spi_MUX,
  output logic                  spi_is_done
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, CAPT, SHIFT, WRITE, DONE
  } state_t;

  state_t                state, state_n;
  logic [1:0]            phase, phase_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic [LEN_WIDTH-1:0]  cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [DATA_WIDTH-1:0] sh, sh_n, shifted;

  logic                  clk_on;
  logic                  sclk1_n, sclk2_n, sel_n;
  logic                  wr_n, mux_n, done_n;
  logic [ADDR_WIDTH-1:0] a_n;
  logic [DATA_WIDTH-1:0] d_n;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      phase       <= '0;
      bit_cnt     <= '0;
      cnt         <= '0;
      addr        <= '0;
      sh          <= '0;
      SCLK1       <= 1'b0;
      SCLK2       <= 1'b0;
      SEL         <= 1'b0;
      CEN         <= 1'b1;
      A           <= '0;
      D           <= '0;
      D_WE        <= 1'b0;
      spi_MUX     <= 1'b0;
      spi_is_done <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      bit_cnt     <= bit_n;
      cnt         <= cnt_n;
      addr        <= addr_n;
      sh          <= sh_n;
      SCLK1       <= sclk1_n;
      SCLK2       <= sclk2_n;
      SEL         <= sel_n;
      CEN         <= ~wr_n;
      A           <= a_n;
      D           <= d_n;
      D_WE        <= wr_n;
      spi_MUX     <= mux_n;
      spi_is_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    bit_n   = bit_cnt;
    cnt_n   = cnt;
    addr_n  = addr;
    sh_n    = sh;
    shifted = {sh[DATA_WIDTH-2:0], SPI_SI};
    unique case (state)
      IDLE: begin
        if (BGN) begin
          addr_n  = ADDR_BGN;
          cnt_n   = DATA_LEN;
          phase_n = '0;
          bit_n   = '0;
          state_n = (DATA_LEN != '0) ? CAPT : DONE;
        end
      end
      CAPT: begin
        phase_n = phase + 2'd1;
        if (phase == 2'd3) begin
          state_n = SHIFT;
          bit_n   = '0;
        end
      end
      SHIFT: begin
        phase_n = phase + 2'd1;
        if (phase == 2'd3) begin
          sh_n  = shifted;
          bit_n = bit_cnt + BW'(1);
          if (bit_cnt == LAST_BIT)
            state_n = WRITE;
        end
      end
      WRITE: begin
        addr_n  = addr - ADDR_WIDTH'(1);
        cnt_n   = cnt - LEN_WIDTH'(1);
        phase_n = '0;
        bit_n   = '0;
        state_n = (cnt == LEN_WIDTH'(1)) ? DONE : SHIFT;
      end
      DONE: begin
        if (!BGN)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it.
    clk_on  = (state_n == CAPT) || (state_n == SHIFT);
    sclk1_n = clk_on && (phase_n == 2'd0);
    sclk2_n = clk_on && (phase_n == 2'd2);
    sel_n   = (state_n == CAPT);
    wr_n    = (state_n == WRITE);
    a_n     = wr_n ? addr : A;
    d_n     = wr_n ? sh_n : D;
    done_n  = (state_n == DONE);

    // SRAM port is handed back one cycle after DONE is entered.
    mux_n = spi_MUX;
    if ((state == IDLE) && BGN)
      mux_n = 1'b1;
    else if (state == DONE)
      mux_n = 1'b0;
  end

endmodule

// File: tb/tb_pseudo_spi_rd_intf.sv
// tb_pseudo_spi_rd_intf: scoreboard bench for pseudo_spi_rd_intf.
// Waveform model plus queued SRAM write expectations.
module tb_pseudo_spi_rd_intf;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int LW = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          BGN = 1'b0;
  logic [AW-1:0] ADDR_BGN = '0;
  logic [LW-1:0] DATA_LEN = '0;
  logic          SPI_SI = 1'b0;
  logic          SCLK1, SCLK2, SEL, CEN, D_WE;
  logic          spi_MUX, spi_is_done;
  logic [AW-1:0] A;
  logic [DW-1:0] D;

  pseudo_spi_rd_intf #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BGN        (BGN),
    .ADDR_BGN   (ADDR_BGN),
    .DATA_LEN   (DATA_LEN),
    .SPI_SI     (SPI_SI),
    .SCLK1      (SCLK1),
    .SCLK2      (SCLK2),
    .SEL        (SEL),
    .CEN        (CEN),
    .A          (A),
    .D          (D),
    .D_WE       (D_WE),
    .spi_MUX    (spi_MUX),
    .spi_is_done(spi_is_done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int       base = 0;
  int       nb = 0;
  int       fall_cyc = 32'h7fffffff;
  bit       active = 1'b0;
  logic [7:0] bytes [4];

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t wq [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic start(input logic [AW-1:0] a, input int n,
                       input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2);
    wr_t w;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    bytes[3] = 8'h00;
    ADDR_BGN = a;
    DATA_LEN = LW'(n);
    BGN      = 1'b1;
    base     = cyc;
    nb       = n;
    fall_cyc = 32'h7fffffff;
    active   = 1'b1;
    for (int k = 0; k < n; k++) begin
      w.c = base + 37 + 33 * k;
      w.a = a - AW'(k);
      w.d = bytes[k];
      wq.push_back(w);
    end
  endtask

  task automatic drop();
    BGN      = 1'b0;
    fall_cyc = cyc + 1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_SCLK1"}, 32'(SCLK1), 0);
    chk({tag, "_SCLK2"}, 32'(SCLK2), 0);
    chk({tag, "_SEL"}, 32'(SEL), 0);
    chk({tag, "_CEN"}, 32'(CEN), 1);
    chk({tag, "_A"}, 32'(A), 0);
    chk({tag, "_D"}, 32'(D), 0);
    chk({tag, "_D_WE"}, 32'(D_WE), 0);
    chk({tag, "_MUX"}, 32'(spi_MUX), 0);
    chk({tag, "_DONE"}, 32'(spi_is_done), 0);
  endtask

  // Analog chain: correct bit only in the sampling phase, inverted otherwise.
  initial begin
    forever begin
      int rel, off, k;
      logic b;
      @(posedge CLK);
      #3;
      rel = cyc - base;
      if (active && nb > 0 && rel >= 5 && rel < 5 + 33 * nb) begin
        off = (rel - 5) % 33;
        k   = (rel - 5) / 33;
        if (off < 32) begin
          b      = bytes[k][7 - off / 4];
          SPI_SI = (off % 4 == 3) ? b : ~b;
        end else begin
          SPI_SI = 1'($urandom_range(0, 1));
        end
      end else begin
        SPI_SI = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: per-cycle waveform model and write scoreboard.
  always @(negedge CLK) begin : mon
    int  rel, off;
    bit  e_sel, e_s1, e_s2, e_we, e_done;
    wr_t w;
    if (RST_N) begin
      rel    = cyc - base;
      e_sel  = 1'b0;
      e_s1   = 1'b0;
      e_s2   = 1'b0;
      e_we   = 1'b0;
      e_done = 1'b0;
      if (active) begin
        if (nb == 0) begin
          e_done = (rel >= 1) && (cyc < fall_cyc);
        end else begin
          if (rel >= 1 && rel <= 4) begin
            e_sel = 1'b1;
            e_s1  = (rel == 1);
            e_s2  = (rel == 3);
          end else if (rel >= 5 && rel < 5 + 33 * nb) begin
            off = (rel - 5) % 33;
            if (off == 32) begin
              e_we = 1'b1;
            end else begin
              e_s1 = (off % 4 == 0);
              e_s2 = (off % 4 == 2);
            end
          end
          e_done = (rel >= 5 + 33 * nb) && (cyc < fall_cyc);
        end
      end
      chk("SEL", 32'(SEL), 32'(e_sel));
      chk("SCLK1", 32'(SCLK1), 32'(e_s1));
      chk("SCLK2", 32'(SCLK2), 32'(e_s2));
      chk("SCLK_overlap", 32'(SCLK1 & SCLK2), 0);
      chk("D_WE", 32'(D_WE), 32'(e_we));
      chk("CEN", 32'(CEN), 32'(!e_we));
      chk("DONE", 32'(spi_is_done), 32'(e_done));
      if (D_WE) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write cycle=%0d got A=%0h D=%0h want none",
                   cyc, A, D);
        end else begin
          w = wq.pop_front();
          chk("write_cycle", 32'(cyc), 32'(w.c));
          chk("write_addr", 32'(A), 32'(w.a));
          chk("write_data", 32'(D), 32'(w.d));
        end
      end
    end
  end

  initial begin
    @(posedge CLK);
    #2;
    chk_reset_vals("reset");
    wait_cyc(cyc + 3);
    RST_N = 1'b1;
    wait_cyc(cyc + 2);

    // single byte, BGN held 20 cycles through DONE
    start(9'h010, 1, 8'hA5, 8'h00, 8'h00);
    wait_cyc(base + 10);
    #2;
    chk("mux_busy", 32'(spi_MUX), 1);
    wait_cyc(base + 45);
    #2;
    chk("mux_released", 32'(spi_MUX), 0);
    wait_cyc(base + 58);
    drop();
    wait_cyc(cyc + 1);

    // restart right after done clears; three bytes down from 0x105
    start(9'h105, 3, 8'h11, 8'h22, 8'h33);
    wait_cyc(base + 104 + 3);
    drop();
    wait_cyc(cyc + 2);

    // address wrap 0x001 -> 0x000 -> 0x1FF
    start(9'h001, 3, 8'hFF, 8'h00, 8'h5A);
    wait_cyc(base + 104 + 2);
    drop();
    wait_cyc(cyc + 2);

    // zero length
    start(9'h0C0, 0, 8'h00, 8'h00, 8'h00);
    wait_cyc(base + 1);
    #2;
    chk("len0_mux_c1", 32'(spi_MUX), 1);
    wait_cyc(base + 2);
    #2;
    chk("len0_mux_c2", 32'(spi_MUX), 0);
    wait_cyc(base + 4);
    drop();
    wait_cyc(cyc + 2);

    // reset in the middle of a two-byte transfer
    start(9'h0AB, 2, 8'hC3, 8'h3C, 8'h00);
    wait_cyc(base + 20);
    RST_N = 1'b0;
    #1;
    chk_reset_vals("midreset");
    active = 1'b0;
    BGN    = 1'b0;
    wq.delete();
    wait_cyc(cyc + 3);
    RST_N = 1'b1;
    wait_cyc(cyc + 1);

    start(9'h0AB, 2, 8'hC3, 8'h3C, 8'h00);
    wait_cyc(base + 71 + 2);
    drop();
    wait_cyc(cyc + 3);

    chk("pending_writes", 32'(wq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
